mem_read_arbiter: RTL and testbench

//  Shares the single 16-bit memory read port between the fetch unit (F) and the load unit (L).

---
 rtl/mem_read_arbiter.sv | 104 ++++++++++
 tb/tb_mem_read_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one 16-bit memory read port between fetch and load.
// Load has fixed priority over fetch. An ordered tag FIFO tracks reads in flight and routes
// each returning word to its owner. A fetch flush discards fetch reads still in flight.
// Optional feature: define ARB_STARVE_LIMIT_EN to force a fetch grant after STARVE_MAX
// consecutive fetch denials caused by load grants.
module mem_read_arbiter #(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_grant,
    output logic        f_rvalid,
    output logic [15:0] f_rdata,
    input  logic        f_flush,
    input  logic        l_req,
    input  logic [15:0] l_addr,
    output logic        l_grant,
    output logic        l_rvalid,
    output logic [15:0] l_rdata,
    output logic        mem_re,
    output logic [15:0] mem_raddr,
    input  logic        mem_ready,
    input  logic [15:0] mem_data_out
);
    localparam int AW = $clog2(MAX_OUT);
    localparam logic [AW:0] FULL = (AW+1)'(MAX_OUT);

    logic          own_l_q [MAX_OUT];
    logic          kill_q  [MAX_OUT];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          slot_ok, force_f, push, pop, head_l, head_kill;

    if (MAX_OUT < 2 || MAX_OUT > 16 || (MAX_OUT & (MAX_OUT - 1)) != 0 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_read_arbiter: MAX_OUT must be a power of 2 in 2..16 and STARVE_MAX >= 1");
    end

`ifdef ARB_STARVE_LIMIT_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    logic [SW-1:0] starve_q, starve_d;

    assign force_f = (starve_q == SMAX) && f_req;

    // Count fetch denials caused by load grants; clears when fetch is granted or idle, saturates.
    always_comb begin
        starve_d = (!f_req || f_grant) ? '0 : (l_grant && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        starve_q <= reset ? '0 : starve_d;
    end
`else
    assign force_f = 1'b0;
`endif

    // Same-cycle grant arbitration and zero-latency routing of the returning word by head tag.
    always_comb begin
        slot_ok   = (occ_q < FULL) || mem_ready;
        l_grant   = !reset && l_req && slot_ok && !force_f;
        f_grant   = !reset && f_req && slot_ok && !l_grant;
        push      = l_grant || f_grant;
        mem_re    = push;
        mem_raddr = l_grant ? l_addr : f_addr;
        pop       = !reset && mem_ready && (occ_q != '0);
        head_l    = own_l_q[rd_q];
        head_kill = kill_q[rd_q];
        l_rvalid  = pop && head_l;
        f_rvalid  = pop && !head_l && !head_kill && !f_flush;
        l_rdata   = mem_data_out;
        f_rdata   = mem_data_out;
        rd_d      = rd_q + AW'(pop);
        wr_d      = wr_q + AW'(push);
        occ_d     = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Tag FIFO; a flush kills every fetch entry, and the entry written this cycle is set last so
    // a fetch pushed during the flush is killed too.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            occ_q <= occ_d;
            for (int i = 0; i < MAX_OUT; i++)
                if (f_flush && !own_l_q[i]) kill_q[i] <= 1'b1;
            if (push) begin
                own_l_q[wr_q] <= l_grant;
                kill_q[wr_q]  <= f_flush && f_grant;
            end
        end
    end

    // Memory may only return a word while a read is in flight.
    assert property (@(posedge clk) disable iff (reset) mem_ready |-> occ_q != '0)
        else $error("mem_read_arbiter: mem_ready with empty tag FIFO");
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed and randomized checks against a queue-based reference model.
module tb_mem_read_arbiter;
    localparam int MAX_OUT    = 4;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        reset, f_req, f_flush, l_req, mem_ready;
    logic [15:0] f_addr, l_addr, mem_data_out;
    logic        f_grant, f_rvalid, l_grant, l_rvalid, mem_re;
    logic [15:0] f_rdata, l_rdata, mem_raddr;

    always #5 clk = ~clk;

    mem_read_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_grant(f_grant), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .f_flush(f_flush),
        .l_req(l_req), .l_addr(l_addr), .l_grant(l_grant), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_ready(mem_ready), .mem_data_out(mem_data_out)
    );

    typedef struct {bit own_l; bit kill; logic [15:0] addr;} tag_t;
    typedef struct {logic [15:0] addr; int due;} rd_t;

    tag_t tags[$];
    rd_t  mq[$];
    int   starve, cyc, lat, checks, errors, frv_cnt, lrv_cnt;
    bit   stall, last_fg, last_lg;

    function automatic logic [15:0] word(logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5a3c;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle(bit fr, logic [15:0] fa, bit lr, logic [15:0] la, bit fl);
        bit mr, force_f, slot, eg_l, eg_f, erl, erf, re_s;
        logic [15:0] ra_s;
        tag_t h, t;
        rd_t r;
        f_req = fr; f_addr = fa; l_req = lr; l_addr = la; f_flush = fl;
        mr = !stall && mq.size() > 0 && mq[0].due <= cyc;
        mem_ready = mr;
        mem_data_out = mr ? word(mq[0].addr) : 16'($urandom);
        #1;
        slot = tags.size() < MAX_OUT || mr;
`ifdef ARB_STARVE_LIMIT_EN
        force_f = starve == STARVE_MAX && fr;
`else
        force_f = 1'b0;
`endif
        eg_l = lr && slot && !force_f;
        eg_f = fr && slot && !eg_l;
        chk("l_grant", l_grant, eg_l);
        chk("f_grant", f_grant, eg_f);
        chk("mem_re", mem_re, eg_l || eg_f);
        if (eg_l || eg_f) chk("mem_raddr", mem_raddr, eg_l ? la : fa);
        if (tags.size() > 0) h = tags[0];
        else begin h.own_l = 0; h.kill = 1; h.addr = 0; end
        erl = mr && h.own_l;
        erf = mr && !h.own_l && !h.kill && !fl;
        chk("l_rvalid", l_rvalid, erl);
        chk("f_rvalid", f_rvalid, erf);
        if (erl) chk("l_rdata", l_rdata, word(h.addr));
        if (erf) chk("f_rdata", f_rdata, word(h.addr));
        last_fg = f_grant; last_lg = l_grant;
        frv_cnt += int'(f_rvalid); lrv_cnt += int'(l_rvalid);
        re_s = mem_re; ra_s = mem_raddr;
        @(posedge clk);
        if (mr) begin
            if (tags.size() > 0) tags.delete(0);
            mq.delete(0);
        end
        if (fl) foreach (tags[i]) if (!tags[i].own_l) tags[i].kill = 1;
        if (eg_l || eg_f) begin
            t.own_l = eg_l; t.kill = fl && eg_f; t.addr = eg_l ? la : fa;
            tags.push_back(t);
        end
        if (re_s) begin
            r.addr = ra_s; r.due = cyc + lat;
            mq.push_back(r);
        end
        if (!fr || eg_f) starve = 0;
        else if (eg_l && starve < STARVE_MAX) starve++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(int n);
        reset = 1; f_req = 1; l_req = 1; f_flush = 1; mem_ready = 1;
        f_addr = 16'h1111; l_addr = 16'h2222; mem_data_out = 16'hdead;
        repeat (n) begin
            #1;
            chk("rst_l_grant", l_grant, 0);
            chk("rst_f_grant", f_grant, 0);
            chk("rst_mem_re", mem_re, 0);
            chk("rst_f_rvalid", f_rvalid, 0);
            chk("rst_l_rvalid", l_rvalid, 0);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        reset = 0; mem_ready = 0; f_req = 0; l_req = 0; f_flush = 0;
        tags.delete(); mq.delete(); starve = 0;
    endtask

    task automatic drain();
        int n = 0;
        stall = 0;
        while ((mq.size() > 0 || tags.size() > 0) && n < 60) begin
            cycle(0, 16'h0, 0, 16'h0, 0);
            n++;
        end
        chk("drain_left", mq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit pf, pl, fl;
        logic [15:0] pfa, pla;
        stall = 0; lat = 1;
        do_reset(2);

        lat = 1; frv_cnt = 0;
        cycle(1, 16'h0000, 0, 16'h0, 0);
        chk("t1_fg", last_fg, 1);
        cycle(0, 16'h0, 0, 16'h0, 0);
        chk("t1_frv", frv_cnt, 1);
        drain();

        frv_cnt = 0; lrv_cnt = 0;
        cycle(1, 16'h0010, 1, 16'h8000, 0);
        chk("t2_lg", last_lg, 1);
        chk("t2_fg", last_fg, 0);
        cycle(1, 16'h0010, 0, 16'h0, 0);
        chk("t2_fg_next", last_fg, 1);
        chk("t2_l_first", lrv_cnt, 1);
        chk("t2_f_not_yet", frv_cnt, 0);
        drain();
        chk("t2_frv", frv_cnt, 1);

        lat = 6;
        for (int i = 0; i < 7; i++) begin
            cycle(1, 16'h0020 + 16'(i), 0, 16'h0, 0);
            chk($sformatf("t3_fg%0d", i), last_fg, (i == 4 || i == 5) ? 0 : 1);
        end
        drain();

        lat = 4; frv_cnt = 0; lrv_cnt = 0;
        cycle(1, 16'h0100, 0, 16'h0, 0);
        cycle(1, 16'h0104, 0, 16'h0, 0);
        cycle(0, 16'h0, 1, 16'h0200, 0);
        cycle(0, 16'h0, 0, 16'h0, 1);
        drain();
        chk("t4_frv", frv_cnt, 0);
        chk("t4_lrv", lrv_cnt, 1);

        lat = 2; frv_cnt = 0;
        cycle(1, 16'h0300, 0, 16'h0, 1);
        drain();
        chk("flush_push_frv", frv_cnt, 0);

        lat = 1;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 16'h0400, 1, 16'h0500, 0);
`ifdef ARB_STARVE_LIMIT_EN
            chk($sformatf("t5_fg%0d", i), last_fg, (i % 4 == 3) ? 1 : 0);
`else
            chk($sformatf("t5_fg%0d", i), last_fg, 0);
`endif
            chk($sformatf("t5_lg%0d", i), last_lg, !last_fg);
        end
        drain();

        lat = 8;
        for (int i = 0; i < 3; i++) cycle(1, 16'h0600 + 16'(i), 0, 16'h0, 0);
        do_reset(1);
        for (int i = 0; i < MAX_OUT; i++) begin
            cycle(1, 16'h0700 + 16'(i), 0, 16'h0, 0);
            chk($sformatf("t6_fg%0d", i), last_fg, 1);
        end
        drain();

        pf = 0; pl = 0; pfa = 0; pla = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pf && $urandom_range(0, 2) != 0) begin pf = 1; pfa = 16'($urandom); end
            if (!pl && $urandom_range(0, 2) != 0) begin pl = 1; pla = 16'($urandom); end
            fl = $urandom_range(0, 9) == 0;
            stall = $urandom_range(0, 3) == 0;
            lat = $urandom_range(1, 4);
            cycle(pf, pfa, pl, pla, fl);
            if (last_fg) pf = 0;
            if (last_lg) pl = 0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
